// File: rtl/pwm_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// pwm_seq_ctrl_if
// Bundles the configuration handshake, the start/stop controls and the PWM
// status outputs of pwm_seq_ctrl.
//
// Compile-time option:
//   PWM_BURST_EN : adds BURST_W and the burst_n signal (burst mode).
//
// Signals:
//   cfg_valid / cfg_ready      : configuration handshake
//   cfg_hi [HI_W]              : high-phase count (phase lasts cfg_hi+1 cycles)
//   cfg_lo [LO_W]              : low-phase count  (phase lasts cfg_lo+1 cycles)
//   start / stop               : single-cycle control requests
//   burst_n [BURST_W]          : periods per burst, 0 = continuous (burst only)
//   out                        : PWM waveform
//   busy                       : generator not idle
//   period_end                 : pulse on the last low cycle of each period
//   done                       : pulse when a burst completes
// Modports: master drives requests, slave is the controller.
// -----------------------------------------------------------------------------
interface pwm_seq_ctrl_if #(
    parameter int HI_W    = 7,
    parameter int LO_W    = 9
`ifdef PWM_BURST_EN
    ,
    parameter int BURST_W = 8
`endif
);
    logic            cfg_valid;
    logic            cfg_ready;
    logic [HI_W-1:0] cfg_hi;
    logic [LO_W-1:0] cfg_lo;
    logic            start;
    logic            stop;
`ifdef PWM_BURST_EN
    logic [BURST_W-1:0] burst_n;
`endif
    logic            out;
    logic            busy;
    logic            period_end;
    logic            done;

`ifdef PWM_BURST_EN
    modport master (
        output cfg_valid, cfg_hi, cfg_lo, start, stop, burst_n,
        input  cfg_ready, out, busy, period_end, done
    );
    modport slave (
        input  cfg_valid, cfg_hi, cfg_lo, start, stop, burst_n,
        output cfg_ready, out, busy, period_end, done
    );
`else
    modport master (
        output cfg_valid, cfg_hi, cfg_lo, start, stop,
        input  cfg_ready, out, busy, period_end, done
    );
    modport slave (
        input  cfg_valid, cfg_hi, cfg_lo, start, stop,
        output cfg_ready, out, busy, period_end, done
    );
`endif
endinterface

// File: rtl/pwm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_seq_ctrl
// PWM sequencer: a HIGH/LOW phase generator whose phase lengths come from
// shadow registers. New settings go into a pending slot first and are promoted
// only while idle or on a LOW->HIGH boundary, so a period never mixes old and
// new values.
//
// Compile-time option:
//   PWM_BURST_EN : stop automatically after burst_n periods (0 = continuous)
//                  and pulse done alongside the final period_end. Without it
//                  generation runs until stop and done is tied low.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active low
//   bus  : pwm_seq_ctrl_if.slave (cfg handshake, start/stop, status outputs)
// -----------------------------------------------------------------------------
module pwm_seq_ctrl #(
    parameter int HI_W    = 7,
    parameter int LO_W    = 9
`ifdef PWM_BURST_EN
    ,
    parameter int BURST_W = 8
`endif
) (
    input  logic          clk,
    input  logic          rst,
    pwm_seq_ctrl_if.slave bus
);
    // One phase counter serves both phases, so it must span the wider count.
    localparam int CW = (HI_W > LO_W) ? HI_W : LO_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [HI_W-1:0] r_hi_act;
    logic [LO_W-1:0] r_lo_act;
    logic [HI_W-1:0] r_hi_pend;
    logic [LO_W-1:0] r_lo_pend;
    logic            r_pend;
    logic            r_out;
    logic            r_pe;

    logic            w_acc;
    logic            w_start;
    logic            w_hi_last;
    logic            w_lo_last;
    logic            w_lo_next_last;
    logic            w_lo_zero;
    logic            w_pe_set;
    logic            w_burst_end;
    logic [CW-1:0]   w_cnt_inc;

    assign w_acc          = bus.cfg_valid && !r_pend;
    // stop beats start; start is only honoured from IDLE.
    assign w_start        = bus.start && !bus.stop && (r_state == S_IDLE);
    assign w_cnt_inc      = r_cnt + 1'b1;
    assign w_hi_last      = (r_state == S_HIGH) && (r_cnt == CW'(r_hi_act));
    assign w_lo_last      = (r_state == S_LOW)  && (r_cnt == CW'(r_lo_act));
    assign w_lo_next_last = (w_cnt_inc == CW'(r_lo_act));
    assign w_lo_zero      = (r_lo_act == '0);

    // period_end is registered, so it is set one edge early: the cycle being
    // entered is the last LOW cycle. lo_act cannot change while in HIGH/LOW
    // (promotion happens only at LOW->HIGH), so the lookahead is stable.
    assign w_pe_set = !bus.stop &&
                      ((w_hi_last && w_lo_zero) ||
                       ((r_state == S_LOW) && !w_lo_last && w_lo_next_last));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_hi_act  <= HI_W'(100);
            r_lo_act  <= LO_W'(400);
            r_hi_pend <= '0;
            r_lo_pend <= '0;
            r_pend    <= 1'b0;
            r_out     <= 1'b0;
            r_pe      <= 1'b0;
        end else begin
            r_pe <= w_pe_set;

            if (w_acc) begin
                r_hi_pend <= bus.cfg_hi;
                r_lo_pend <= bus.cfg_lo;
                r_pend    <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_out <= 1'b0;
                    r_cnt <= '0;
                    if (r_pend) begin
                        r_hi_act <= r_hi_pend;
                        r_lo_act <= r_lo_pend;
                        r_pend   <= 1'b0;
                    end
                    if (w_start) begin
                        r_state <= S_HIGH;
                        r_out   <= 1'b1;
                        // A config offered alongside start bypasses the
                        // pending slot so it governs the very first HIGH cycle.
                        if (w_acc) begin
                            r_hi_act <= bus.cfg_hi;
                            r_lo_act <= bus.cfg_lo;
                            r_pend   <= 1'b0;
                        end
                    end
                end

                S_HIGH: begin
                    if (bus.stop) begin
                        r_state <= S_IDLE;
                        r_out   <= 1'b0;
                        r_cnt   <= '0;
                    end else if (w_hi_last) begin
                        r_state <= S_LOW;
                        r_out   <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end

                S_LOW: begin
                    if (bus.stop) begin
                        r_state <= S_IDLE;
                        r_out   <= 1'b0;
                        r_cnt   <= '0;
                    end else if (w_lo_last) begin
                        r_cnt <= '0;
                        if (w_burst_end) begin
                            r_state <= S_IDLE;
                            r_out   <= 1'b0;
                        end else begin
                            r_state <= S_HIGH;
                            r_out   <= 1'b1;
                            // Period boundary: the only safe point to swap
                            // in new phase lengths while running.
                            if (r_pend) begin
                                r_hi_act <= r_hi_pend;
                                r_lo_act <= r_lo_pend;
                                r_pend   <= 1'b0;
                            end
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_out   <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef PWM_BURST_EN
    logic [BURST_W-1:0] r_burst;
    logic [BURST_W-1:0] r_pcnt;
    logic [BURST_W-1:0] w_pcnt_inc;
    logic               r_done;

    assign w_pcnt_inc  = r_pcnt + 1'b1;
    // r_pcnt holds the number of completed periods, so the period now ending
    // is number r_pcnt+1. burst_n==0 never matches: continuous mode.
    assign w_burst_end = (r_burst != '0) && (w_pcnt_inc == r_burst);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_burst <= '0;
            r_pcnt  <= '0;
            r_done  <= 1'b0;
        end else begin
            // Same lookahead as period_end so both pulses coincide.
            r_done <= w_pe_set && w_burst_end;
            if (w_start) begin
                r_burst <= bus.burst_n;
                r_pcnt  <= '0;
            end else if (w_lo_last && !bus.stop) begin
                r_pcnt  <= w_burst_end ? '0 : w_pcnt_inc;
            end
        end
    end

    assign bus.done = r_done;
`else
    assign w_burst_end = 1'b0;
    assign bus.done    = 1'b0;
`endif

    assign bus.cfg_ready  = !r_pend;
    assign bus.out        = r_out;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.period_end = r_pe;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
`timescale 1ns/1ps
module tb_pwm_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pwm_seq_ctrl_if bus ();

    pwm_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Expected shape of each completed period, pushed by the stimulus.
    typedef struct {
        int hi;
        int lo;
        bit dn;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   pe_seen = 0;
    int   hc      = 0;
    int   lc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: measures high/low run lengths and compares each period at its
    // period_end pulse against the next scoreboard entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst || !bus.busy) begin
            hc = 0;
            lc = 0;
        end else if (bus.out) begin
            hc++;
        end else begin
            lc++;
        end
        if (bus.done === 1'b1 && bus.period_end !== 1'b1)
            chk("stray_done", 1, 0);
        if (bus.period_end === 1'b1) begin
            pe_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_period_end", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("hi_len", hc, e.hi);
                chk("lo_len", lc, e.lo);
                chk("done_at_pe", bus.done, {31'd0, e.dn});
            end
            hc = 0;
            lc = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int hi, input int lo, input bit dn, input int n);
        exp_t e;
        e.hi = hi; e.lo = lo; e.dn = dn;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic send_cfg(input logic [6:0] hi, input logic [8:0] lo);
        bus.cfg_hi    = hi;
        bus.cfg_lo    = lo;
        bus.cfg_valid = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    task automatic wait_pe(input int tgt, input int budget, input string name);
        int n = 0;
        while (pe_seen < tgt && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (pe_seen < tgt) chk({name, "_timeout"}, pe_seen, tgt);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_cfg_ready"}, bus.cfg_ready, 1);
        chk({tag, "_out"}, bus.out, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_period_end"}, bus.period_end, 0);
        chk({tag, "_done"}, bus.done, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        bus.cfg_valid = 1'b0;
        bus.cfg_hi    = '0;
        bus.cfg_lo    = '0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
`ifdef PWM_BURST_EN
        bus.burst_n   = '0;
`endif
        rst = 1'b0;
        repeat (3) tick();
        chk_reset_outs("reset");
        rst = 1'b1;
        tick();

        // Defaults 100/400: 101 high, 401 low, out rises right after start.
        push(101, 401, 1'b0, 2);
        chk("out_before_start", bus.out, 0);
        pulse_start();
        chk("out_rise", bus.out, 1);
        chk("busy_run", bus.busy, 1);
        wait_pe(2, 1200, "default");
        pulse_stop();
        chk("stop1_out", bus.out, 0);
        chk("stop1_busy", bus.busy, 0);

        // 3/5 offered mid-HIGH: current period finishes on old values.
        base = pe_seen;
        pulse_start();
        repeat (20) tick();
        send_cfg(7'd3, 9'd5);
        chk("ready_pending", bus.cfg_ready, 0);
        push(101, 401, 1'b0, 1);
        push(4, 6, 1'b0, 2);
        wait_pe(base + 1, 700, "mid_cfg_first");
        chk("ready_until_boundary", bus.cfg_ready, 0);
        tick();
        chk("ready_after_boundary", bus.cfg_ready, 1);
        wait_pe(base + 3, 100, "mid_cfg_next");
        pulse_stop();
        chk("stop2_busy", bus.busy, 0);

        // 0/0: one-cycle phases, period_end every second cycle.
        base = pe_seen;
        send_cfg(7'd0, 9'd0);
        chk("idle_ready_pending", bus.cfg_ready, 0);
        tick();
        chk("idle_ready_copied", bus.cfg_ready, 1);
        push(1, 1, 1'b0, 4);
        pulse_start();
        chk("zero_out_hi", bus.out, 1);
        chk("zero_pe_lo", bus.period_end, 0);
        tick();
        chk("zero_out_lo", bus.out, 0);
        chk("zero_pe_hi", bus.period_end, 1);
        wait_pe(base + 4, 50, "zero_cfg");
        pulse_stop();
        chk("stop3_busy", bus.busy, 0);

        // stop together with start in the 50th HIGH cycle.
        send_cfg(7'd100, 9'd400);
        tick();
        pulse_start();
        repeat (49) tick();
        bus.stop  = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        chk("stop_start_out", bus.out, 0);
        chk("stop_start_busy", bus.busy, 0);
        repeat (5) tick();
        chk("stop_start_stays_idle", bus.busy, 0);

        // Reset mid-LOW with a pending config: back to 100/400 defaults.
        send_cfg(7'd7, 9'd7);
        tick();
        pulse_start();
        repeat (11) tick();
        chk("pre_reset_in_low", bus.out, 0);
        send_cfg(7'd3, 9'd5);
        chk("pre_reset_pending", bus.cfg_ready, 0);
        rst = 1'b0;
        tick();
        chk_reset_outs("midlow_reset");
        rst = 1'b1;
        tick();
        base = pe_seen;
        push(101, 401, 1'b0, 1);
        pulse_start();
        wait_pe(base + 1, 700, "after_reset");
        pulse_stop();
        chk("stop4_busy", bus.busy, 0);

`ifdef PWM_BURST_EN
        // Burst of 3 periods at 2/2, run twice.
        send_cfg(7'd2, 9'd2);
        tick();
        bus.burst_n = 8'd3;
        for (int r = 0; r < 2; r++) begin
            base = pe_seen;
            push(3, 3, 1'b0, 2);
            push(3, 3, 1'b1, 1);
            pulse_start();
            wait_pe(base + 3, 60, "burst");
            tick();
            chk("burst_idle_busy", bus.busy, 0);
            chk("burst_idle_out", bus.out, 0);
            repeat (10) tick();
            chk("burst_no_extra", pe_seen, base + 3);
        end
`endif

        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pwm_seq_ctrl.md
PWM_SEQ_CTRL -- requirements
Module: pwm_seq_ctrl

Interface
REQ-001 Parameter HI_W, default 7: width of the high-phase count.
REQ-002 Parameter LO_W, default 9: width of the low-phase count.
REQ-003 Parameter BURST_W, default 8: width of the burst-length count.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 cfg_valid  input  1  a new high/low configuration is offered.
REQ-007 cfg_ready  output  1  the block can accept a configuration.
REQ-008 cfg_hi  input  HI_W  high-phase count; high phase lasts cfg_hi+1 cycles.
REQ-009 cfg_lo  input  LO_W  low-phase count; low phase lasts cfg_lo+1 cycles.
REQ-010 start  input  1  single-cycle request to begin generation.
REQ-011 stop  input  1  single-cycle request to abort generation.
REQ-012 burst_n  input  BURST_W  number of periods per burst; 0 means continuous (present only with PWM_BURST_EN).
REQ-013 out  output  1  registered PWM waveform.
REQ-014 busy  output  1  high whenever the state is not IDLE.
REQ-015 period_end  output  1  one-cycle pulse on the last cycle of each low phase.
REQ-016 done  output  1  one-cycle pulse when a burst completes.

Function
REQ-017 The FSM SHALL have three states, IDLE, HIGH and LOW, with out=1 only in HIGH.
REQ-018 Active hi/lo values SHALL be held in shadow registers, hi_act and lo_act.
REQ-019 A configuration is accepted on a cycle with cfg_valid&&cfg_ready, and the values are latched into pending registers with a pending flag set.
REQ-020 cfg_ready SHALL be 0 while the pending flag is set, and 1 otherwise.
REQ-021 In IDLE, pending values SHALL be copied to hi_act/lo_act on the cycle after acceptance, and the flag cleared.
REQ-022 In HIGH or LOW, pending values SHALL be copied only on the LOW->HIGH boundary, so that no period mixes old and new values.
REQ-023 start in IDLE SHALL move the FSM to HIGH on the next edge with the phase counter at 0, so out rises one cycle after start.
REQ-024 In HIGH, the counter increments each cycle; when counter==hi_act, the FSM SHALL go to LOW and clear the counter.
REQ-025 In LOW, the counter increments each cycle; when counter==lo_act, the FSM SHALL assert period_end that cycle and return to HIGH with the counter cleared.
REQ-026 A period SHALL be exactly hi_act+lo_act+2 cycles; a count of 0 gives a one-cycle phase.
REQ-027 The counter width SHALL be max(HI_W,LO_W), with no wrap before the compare matches.
REQ-028 start while busy SHALL be ignored.
REQ-029 stop SHALL force IDLE and out=0 on the next edge from any state, with no period_end and no done.
REQ-030 If start and stop are asserted together, stop SHALL win.
REQ-031 A configuration accepted on the same cycle as start SHALL take effect before the first HIGH cycle.

Reset
REQ-032 While rst=0 at a clock edge: state=IDLE, counter=0, out=0, period_end=0, done=0, pending flag=0, cfg_ready=1, hi_act=100, lo_act=400, period count=0.
REQ-033 Reset mid-period SHALL abandon the period, and any pending configuration SHALL be discarded.

Configuration
REQ-034 The macro PWM_BURST_EN SHALL compile the burst feature in or out.
REQ-035 With PWM_BURST_EN defined: burst_n is latched on start; a BURST_W period counter counts period_end pulses; when the count reaches a nonzero burst_n, the FSM SHALL go to IDLE instead of HIGH and pulse done on that same cycle as period_end; burst_n=0 runs continuously.
REQ-036 Without PWM_BURST_EN: the burst_n port and period counter are absent, generation is continuous until stop, and done is tied to 0.

Verification
REQ-037 Reset release, start with defaults: out rises 1 cycle after start, is high for 101 cycles and low for 401 cycles, and period_end pulses every 502 cycles.
REQ-038 cfg_hi=3, cfg_lo=5 accepted mid-HIGH of a default period: the current period finishes at 101/401, the next period is 4/6, and cfg_ready=0 until the boundary.
REQ-039 cfg_hi=0, cfg_lo=0: out toggles every cycle, and period_end is high every second cycle.
REQ-040 stop in the 50th HIGH cycle, with start asserted in the same cycle: out=0 and busy=0 on the next edge, and no period_end.
REQ-041 PWM_BURST_EN, burst_n=3, cfg 2/2: exactly 3 periods of 3 high/3 low, done coincides with the 3rd period_end, then IDLE; a second start repeats this.
REQ-042 rst=0 asserted mid-LOW with a pending configuration: all outputs return to reset values, and after restart the period is 101/401.
